// File: rtl/npu_gemm_pkg.sv
// Shared types and width helpers for the GEMM drive-side feeder.
package npu_gemm_pkg;

    localparam int unsigned PKG_ARRAY_SIZE = 16;
    localparam int unsigned STREAM_LEN     = 2 * PKG_ARRAY_SIZE - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT_ARRAY,
        ST_START,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_DONE
    } feeder_state_t;

    // Bits needed to index n entries (0..n-1).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Cycles needed to stream a fully skewed n-wide tile.
    function automatic int unsigned stream_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/gemm_act_buffer.sv
// Activation tile buffer: N vectors of N elements, one vector write port and
// a combinational diagonally-skewed read port indexed by stream step s.
//   clk       : clock
//   i_we      : write strobe for one activation vector
//   i_waddr   : vector index k
//   i_wdata   : vector k, element c in bits [c*DW +: DW]
//   i_s       : stream step
//   o_skew_c  : element c = buf[s-c][c] when 0 <= s-c < N, else 0
module gemm_act_buffer
    import npu_gemm_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = PKG_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               i_we,
    input  logic [$clog2(ARRAY_SIZE)-1:0]      i_waddr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   i_wdata,
    input  logic [$clog2(2*ARRAY_SIZE)-1:0]    i_s,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   o_skew_c
);

    localparam int unsigned IW = idx_width(ARRAY_SIZE);
    localparam int unsigned SW = idx_width(2 * ARRAY_SIZE);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;

    logic [VW-1:0] r_mem [ARRAY_SIZE];
    logic [SW:0]   w_k;

    // Vector write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Skewed read: s - c underflows into the extra MSB when column c has not
    // started yet, which doubles as the "before window" test.
    always_comb begin
        o_skew_c = '0;
        w_k      = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            w_k = {1'b0, i_s} - (SW+1)'(c);
            if (!w_k[SW] && (w_k < (SW+1)'(ARRAY_SIZE))) begin
                o_skew_c[c*DW +: DW] = r_mem[w_k[IW-1:0]][c*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/gemm_feeder.sv
// Drive-side sequencer for the weight-stationary systolic array: takes a tile
// command, collects N weight rows and N activation vectors, pushes weights
// row by row, starts the array and streams skewed activations.
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_clear: tile command (clear_acc before load)
//   w_valid/w_ready/w_data       : weight-row stream
//   a_valid/a_ready/a_data       : activation-vector stream
//   load_weights/weight_row/weight_in : array weight load port
//   start_compute, clear_acc     : one-cycle array strobes
//   activation_in/activation_valid : skewed activation stream
//   array_busy                   : array status
//   busy, done                   : feeder status, tile-complete pulse
module gemm_feeder
    import npu_gemm_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = PKG_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_clear,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   w_data,
    input  logic                               a_valid,
    output logic                               a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   a_data,
    output logic                               load_weights,
    output logic [$clog2(ARRAY_SIZE)-1:0]      weight_row,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   weight_in,
    output logic                               start_compute,
    output logic                               clear_acc,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   activation_in,
    output logic                               activation_valid,
    input  logic                               array_busy,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned IW   = idx_width(ARRAY_SIZE);
    localparam int unsigned CW   = cnt_width(ARRAY_SIZE);
    localparam int unsigned SW   = idx_width(2 * ARRAY_SIZE);
    localparam int unsigned VW   = ARRAY_SIZE * DATA_WIDTH;
    localparam int unsigned SLEN = stream_len(ARRAY_SIZE);

    feeder_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_wcnt, w_wcnt_nxt;
    logic [CW-1:0] r_acnt, w_acnt_nxt;
    logic [SW-1:0] r_s, w_s_nxt;

    logic          w_cmd_acc, w_w_acc, w_a_acc;
    logic [VW-1:0] w_skew_c;

    logic          w_cmd_ready_nxt, w_w_ready_nxt, w_a_ready_nxt;
    logic          w_load_nxt, w_start_nxt, w_clear_nxt;
    logic          w_act_valid_nxt, w_busy_nxt, w_done_nxt;
    logic [IW-1:0] w_row_nxt;
    logic [VW-1:0] w_win_nxt, w_act_nxt;

    assign w_cmd_acc = cmd_valid & cmd_ready;
    assign w_w_acc   = w_valid & w_ready;
    assign w_a_acc   = a_valid & a_ready;

    gemm_act_buffer #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_act_buffer (
        .clk      (clk),
        .i_we     (w_a_acc),
        .i_waddr  (r_acnt[IW-1:0]),
        .i_wdata  (a_data),
        .i_s      (w_s_nxt),
        .o_skew_c (w_skew_c)
    );

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_wcnt           <= '0;
            r_acnt           <= '0;
            r_s              <= '0;
            cmd_ready        <= 1'b1;
            w_ready          <= 1'b0;
            a_ready          <= 1'b0;
            load_weights     <= 1'b0;
            weight_row       <= '0;
            weight_in        <= '0;
            start_compute    <= 1'b0;
            clear_acc        <= 1'b0;
            activation_in    <= '0;
            activation_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_wcnt           <= w_wcnt_nxt;
            r_acnt           <= w_acnt_nxt;
            r_s              <= w_s_nxt;
            cmd_ready        <= w_cmd_ready_nxt;
            w_ready          <= w_w_ready_nxt;
            a_ready          <= w_a_ready_nxt;
            load_weights     <= w_load_nxt;
            weight_row       <= w_row_nxt;
            weight_in        <= w_win_nxt;
            start_compute    <= w_start_nxt;
            clear_acc        <= w_clear_nxt;
            activation_in    <= w_act_nxt;
            activation_valid <= w_act_valid_nxt;
            busy             <= w_busy_nxt;
            done             <= w_done_nxt;
        end
    end

    // Next state, counters and next-cycle output values.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_acnt_nxt  = r_acnt;
        w_s_nxt     = r_s;

        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    w_wcnt_nxt  = '0;
                    w_acnt_nxt  = '0;
                    w_state_nxt = cmd_clear ? ST_CLEAR : ST_LOAD;
                end
            end
            ST_CLEAR: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (w_w_acc) w_wcnt_nxt = r_wcnt + CW'(1);
                if (w_a_acc) w_acnt_nxt = r_acnt + CW'(1);
                if ((w_wcnt_nxt == CW'(ARRAY_SIZE)) && (w_acnt_nxt == CW'(ARRAY_SIZE))) begin
                    w_state_nxt = ST_WAIT_ARRAY;
                end
            end
            ST_WAIT_ARRAY: begin
                if (!array_busy) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_s_nxt     = '0;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_s == SW'(SLEN - 1)) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    w_s_nxt = r_s + SW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!array_busy) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they line up with it.
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_w_ready_nxt   = (w_state_nxt == ST_LOAD) && (w_wcnt_nxt < CW'(ARRAY_SIZE));
        w_a_ready_nxt   = (w_state_nxt == ST_LOAD) && (w_acnt_nxt < CW'(ARRAY_SIZE));
        w_clear_nxt     = (w_state_nxt == ST_CLEAR);
        w_start_nxt     = (w_state_nxt == ST_START);
        w_act_valid_nxt = (w_state_nxt == ST_STREAM);
        w_act_nxt       = (w_state_nxt == ST_STREAM) ? w_skew_c : '0;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_nxt      = (w_state_nxt == ST_DONE);

        // Weight rows pass straight through, one cycle after acceptance.
        w_load_nxt = w_w_acc;
        w_row_nxt  = w_w_acc ? r_wcnt[IW-1:0] : weight_row;
        w_win_nxt  = w_w_acc ? w_data : weight_in;
    end

endmodule

// File: tb/tb_gemm_feeder.sv
// Directed self-checking bench for gemm_feeder (N=16, 8-bit elements).
module tb_gemm_feeder;
    import npu_gemm_pkg::*;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_clear;
    logic          w_valid, w_ready;
    logic [VW-1:0] w_data;
    logic          a_valid, a_ready;
    logic [VW-1:0] a_data;
    logic          load_weights;
    logic [3:0]    weight_row;
    logic [VW-1:0] weight_in;
    logic          start_compute, clear_acc;
    logic [VW-1:0] activation_in;
    logic          activation_valid;
    logic          array_busy, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_clear = 0, cnt_start = 0, cnt_done = 0, cnt_load = 0;
    int c_clear0, c_start0, c_done0, c_load0;

    logic [7:0] wmat [N][N];
    logic [7:0] amat [N][N];

    always #5 clk = ~clk;

    gemm_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_clear        (cmd_clear),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_data           (a_data),
        .load_weights     (load_weights),
        .weight_row       (weight_row),
        .weight_in        (weight_in),
        .start_compute    (start_compute),
        .clear_acc        (clear_acc),
        .activation_in    (activation_in),
        .activation_valid (activation_valid),
        .array_busy       (array_busy),
        .busy             (busy),
        .done             (done)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (clear_acc)     cnt_clear++;
        if (start_compute) cnt_start++;
        if (done)          cnt_done++;
        if (load_weights)  cnt_load++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] wrow(input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = wmat[r][c];
        return v;
    endfunction

    function automatic logic [VW-1:0] avec(input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = amat[k][c];
        return v;
    endfunction

    // Reference skew: column c carries A[s-c][c] inside the window.
    function automatic logic [VW-1:0] skew(input int s);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            if ((s - c) >= 0 && (s - c) < N) v[c*DW +: DW] = amat[s-c][c];
        end
        return v;
    endfunction

    task automatic mark();
        c_clear0 = cnt_clear; c_start0 = cnt_start; c_done0 = cnt_done; c_load0 = cnt_load;
    endtask

    // Issue a command and load both streams at full rate; returns in START cycle.
    task automatic load_full(input logic clr);
        chk("idle_cmd_ready", VW'(cmd_ready), VW'(1));
        cmd_valid = 1'b1; cmd_clear = clr;
        tick();
        cmd_valid = 1'b0; cmd_clear = 1'b0;
        if (clr) begin
            chk("clear_pulse", VW'(clear_acc), VW'(1));
            chk("no_ready_in_clear", VW'(w_ready), VW'(0));
            tick();
            chk("clear_single", VW'(clear_acc), VW'(0));
        end
        chk("load_ready", VW'({w_ready, a_ready}), VW'(2'b11));
        for (int r = 0; r < N; r++) begin
            w_valid = 1'b1; a_valid = 1'b1;
            w_data = wrow(r); a_data = avec(r);
            tick();
            chk($sformatf("load_row%0d", r), {load_weights, weight_row, weight_in},
                {1'b1, 4'(r), wrow(r)});
        end
        w_valid = 1'b0; a_valid = 1'b0;
        chk("ready_after_n", VW'({w_ready, a_ready}), VW'(0));
        tick();
        chk("start_timing", VW'(start_compute), VW'(1));
    endtask

    // From START cycle: check all stream cycles, end in the WAIT_DONE cycle.
    task automatic stream_check(input string tag, input logic col3_hand);
        for (int s = 0; s < STREAM_LEN; s++) begin
            tick();
            chk($sformatf("%s_valid_s%0d", tag, s), VW'({activation_valid, start_compute, cmd_ready}),
                VW'(3'b100));
            chk($sformatf("%s_act_s%0d", tag, s), activation_in, skew(s));
            if (col3_hand)
                chk($sformatf("%s_col3_s%0d", tag, s), VW'(activation_in[3*DW +: DW]),
                    VW'((s >= 3 && s <= 18) ? s - 3 : 0));
        end
        tick();
        chk({tag, "_stream_end"}, VW'({activation_valid, done, busy}), VW'(3'b001));
    endtask

    task automatic finish_tile(input string tag);
        tick();
        chk({tag, "_done"}, VW'({done, busy, cmd_ready}), VW'(3'b110));
        tick();
        chk({tag, "_idle"}, VW'({done, busy, cmd_ready}), VW'(3'b001));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0;
        w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
        array_busy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("reset_outputs", VW'({busy, done, load_weights, start_compute, clear_acc,
                                  activation_valid, w_ready, a_ready}), VW'(0));
        chk("reset_cmd_ready", VW'(cmd_ready), VW'(1));
        chk("reset_act", activation_in, '0);

        // Tile 1: clear, W=r+c, A=k, full rate
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wmat[i][j] = 8'(i + j);
                amat[i][j] = 8'(i);
            end
        mark();
        load_full(1'b1);
        stream_check("t1", 1'b1);
        finish_tile("t1");
        chk("t1_clear_cnt", VW'(cnt_clear - c_clear0), VW'(1));
        chk("t1_start_cnt", VW'(cnt_start - c_start0), VW'(1));
        chk("t1_load_cnt",  VW'(cnt_load - c_load0),   VW'(16));
        chk("t1_done_cnt",  VW'(cnt_done - c_done0),   VW'(1));

        // Tile 2: activations first, toggling weights, array busy, extra beats
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wmat[i][j] = 8'(i * 16 + j + 1);
                amat[i][j] = 8'((i * 16 + j) ^ 8'hA5);
            end
        mark();
        array_busy = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t2_no_clear", VW'({clear_acc, w_ready, a_ready}), VW'(3'b011));
        for (int k = 0; k < N; k++) begin
            a_valid = 1'b1; a_data = avec(k);
            tick();
        end
        a_data = '1;
        chk("t2_a_full", VW'({a_ready, w_ready, load_weights}), VW'(3'b010));
        for (int r = 0; r < N; r++) begin
            w_valid = 1'b1; w_data = wrow(r);
            tick();
            chk($sformatf("t2_row%0d", r), {load_weights, weight_row, weight_in},
                {1'b1, 4'(r), wrow(r)});
            w_valid = 1'b0; w_data = '1;
            tick();
            chk($sformatf("t2_gap%0d", r), VW'({load_weights, start_compute}), VW'(0));
        end
        w_valid = 1'b1;
        repeat (20) tick();
        chk("t2_held_by_busy", VW'({cnt_start - c_start0, 1'b0}), VW'(0));
        chk("t2_extra_ignored", VW'({w_ready, a_ready, load_weights}), VW'(0));
        chk("t2_load_cnt", VW'(cnt_load - c_load0), VW'(16));
        array_busy = 1'b0;
        tick();
        chk("t2_start_after_busy", VW'(start_compute), VW'(1));
        cmd_valid = 1'b1;
        stream_check("t2", 1'b0);
        cmd_valid = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        array_busy = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_wait_done", VW'({done, busy}), VW'(2'b01));
        end
        array_busy = 1'b0;
        finish_tile("t2");
        chk("t2_pulses", VW'({8'(cnt_start - c_start0), 8'(cnt_done - c_done0),
                              8'(cnt_clear - c_clear0)}), VW'({8'd1, 8'd1, 8'd0}));

        // Tile 3: reset mid-stream at s=5, then a clean tile
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wmat[i][j] = 8'(255 - i * 3 - j);
                amat[i][j] = 8'(i * 7 + j * 3 + 1);
            end
        load_full(1'b0);
        for (int s = 0; s <= 5; s++) tick();
        chk("t3_streaming_s5", {activation_valid, activation_in}, {1'b1, skew(5)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_after_reset", VW'({activation_valid, start_compute, busy, cmd_ready, done}),
            VW'(5'b00010));
        chk("t3_after_reset_act", activation_in, '0);
        mark();
        load_full(1'b1);
        stream_check("t4", 1'b0);
        finish_tile("t4");
        chk("t4_pulses", VW'({8'(cnt_start - c_start0), 8'(cnt_done - c_done0),
                              8'(cnt_clear - c_clear0)}), VW'({8'd1, 8'd1, 8'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
